// File: rtl/pipe_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | pipe_ctrl_pkg : shared constants for the pipeline sequencer          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package pipe_ctrl_pkg;

  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  typedef logic [31:0] inst_addr_t;

  // stall vector bits: [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  function automatic logic [5:0] merge_stall(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
    logic [5:0] v;
    if (req_mem)     v = STALL_MEM;
    else if (req_ex) v = STALL_EX;
    else if (req_id) v = STALL_ID;
    else if (req_if) v = STALL_IF;
    else             v = STALL_NONE;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stall_watchdog.sv
// +----------------------------------------------------------------------+
// | pipe_stall_watchdog : sticky flag after STALL_TIMEOUT stalled cycles |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pipe_stall_watchdog import pipe_ctrl_pkg::*; #(
  parameter int STALL_TIMEOUT = 1023,
  parameter int WD_W          = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled,
  output logic timeout_o
);

  localparam logic [WD_W-1:0] LIMIT = WD_W'(STALL_TIMEOUT);

  logic [WD_W-1:0] cnt_q, cnt_d;
  logic            to_q, to_d;

  always_comb begin
    cnt_d = cnt_q;
    to_d  = to_q;
    if (!stalled)           cnt_d = '0;
    else if (cnt_q != LIMIT) cnt_d = cnt_q + 1'b1;
    if (stalled && cnt_d == LIMIT) to_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout_o = to_q;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// +----------------------------------------------------------------------+
// | pipe_ctrl : stall merge, mispredict flush/redirect FSM, watchdog     |
// | Optional perf counters under PIPE_CTRL_PERF_EN. Rev 1.0              |
// +----------------------------------------------------------------------+
`default_nettype none

module pipe_ctrl import pipe_ctrl_pkg::*; #(
  parameter int STALL_TIMEOUT = 1023,
  parameter int WD_W          = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        pdt_miss_i,
  input  logic [31:0] pdt_target_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] perf_stall_cyc_o,
  output logic [31:0] perf_flush_cnt_o,
`endif
  output logic        timeout_o
);

  logic [0:0] state_q, state_d;
  inst_addr_t pend_q, pend_d;
  logic       blocked;
  logic       flush_d;
  inst_addr_t pc_d;

  assign blocked = stallreq_ex | stallreq_mem;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    flush_d = 1'b0;
    pc_d    = ZERO_WORD;
    case (state_q)
      ST_IDLE: begin
        if (pdt_miss_i && !blocked) begin
          flush_d = 1'b1;
          pc_d    = pdt_target_i;
        end else if (pdt_miss_i) begin
          pend_d  = pdt_target_i;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        // The held branch keeps re-asserting its miss; only the latched target matters.
        if (!blocked) begin
          flush_d = 1'b1;
          pc_d    = pend_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst == RST_ENABLE) begin
      flush_d = 1'b0;
      pc_d    = ZERO_WORD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= ST_IDLE;
      pend_q  <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  assign flush_o       = flush_d;
  assign redirect_o    = flush_d;
  assign redirect_pc_o = pc_d;
  assign stall_o       = (flush_d || rst == RST_ENABLE) ? STALL_NONE
                       : merge_stall(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);

  pipe_stall_watchdog #(
    .STALL_TIMEOUT (STALL_TIMEOUT),
    .WD_W          (WD_W)
  ) u_wd (
    .clk       (clk),
    .rst       (rst),
    .stalled   (|stall_o),
    .timeout_o (timeout_o)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cyc_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (|stall_o) stall_cyc_q <= stall_cyc_q + 32'd1;
      if (flush_o)  flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cyc_o = stall_cyc_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_pipe_ctrl : directed vector bench for pipe_ctrl                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_if, r_id, r_ex, r_mem, miss;
  logic [31:0] target;
  logic [5:0]  stall_o;
  logic        flush_o, redirect_o, timeout_o;
  logic [31:0] redirect_pc_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc_o, perf_flush_cnt_o;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.STALL_TIMEOUT(8), .WD_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (r_if),
    .stallreq_id   (r_id),
    .stallreq_ex   (r_ex),
    .stallreq_mem  (r_mem),
    .pdt_miss_i    (miss),
    .pdt_target_i  (target),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
`ifdef PIPE_CTRL_PERF_EN
    .perf_stall_cyc_o (perf_stall_cyc_o),
    .perf_flush_cnt_o (perf_flush_cnt_o),
`endif
    .timeout_o     (timeout_o)
  );

  typedef struct {
    logic        i_if, i_id, i_ex, i_mem, i_miss;
    logic [31:0] i_tgt;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic drive(input logic a, input logic b, input logic c, input logic d,
                       input logic m, input logic [31:0] t);
    r_if = a; r_id = b; r_ex = c; r_mem = d; miss = m; target = t;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [5:0] st, input logic fl,
                         input logic [31:0] pc);
    chk({nm, ".stall"}, {26'd0, stall_o}, {26'd0, st});
    chk({nm, ".flush"}, {31'd0, flush_o}, {31'd0, fl});
    chk({nm, ".redir"}, {31'd0, redirect_o}, {31'd0, fl});
    chk({nm, ".pc"},    redirect_pc_o, pc);
  endtask

  initial begin
    vecs[0] = '{1,1,0,0,0,32'h0,    6'b000111, 0, 32'h0};
    vecs[1] = '{1,1,0,1,0,32'h0,    6'b011111, 0, 32'h0};
    vecs[2] = '{0,0,0,0,0,32'h0,    6'b000000, 0, 32'h0};
    vecs[3] = '{1,0,0,0,0,32'h0,    6'b000011, 0, 32'h0};
    vecs[4] = '{0,0,1,0,0,32'h0,    6'b001111, 0, 32'h0};
    vecs[5] = '{0,1,1,0,0,32'h0,    6'b001111, 0, 32'h0};
    vecs[6] = '{0,0,0,0,1,32'h40,   6'b000000, 1, 32'h40};
    vecs[7] = '{0,1,0,0,1,32'h80,   6'b000000, 1, 32'h80};
    vecs[8] = '{1,0,0,0,1,32'h1234, 6'b000000, 1, 32'h1234};

    // reset cycle: outputs forced quiet even with active requests
    rst = 1'b1;
    drive(0,0,0,1,1,32'h55);
    chk_out("rst", 6'b0, 0, 32'h0);
    step();
    chk("rst.timeout", {31'd0, timeout_o}, 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    chk("rst.perf_stall", perf_stall_cyc_o, 32'd0);
    chk("rst.perf_flush", perf_flush_cnt_o, 32'd0);
`endif
    rst = 1'b0;
    drive(0,0,0,0,0,32'h0);
    step();

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].i_if, vecs[i].i_id, vecs[i].i_ex, vecs[i].i_mem, vecs[i].i_miss, vecs[i].i_tgt);
      chk_out($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_pc);
      step();
    end

    // blocked miss: deferred until mem drops, latched target used, single flush
    drive(0,0,0,1,1,32'h100);
    chk_out("pend0", 6'b011111, 0, 32'h0);
    step();
    for (int i = 1; i < 3; i++) begin
      drive(0,0,0,1,1,32'hDEAD);
      chk_out($sformatf("pend%0d", i), 6'b011111, 0, 32'h0);
      step();
    end
    drive(0,0,0,0,1,32'hBAD);
    chk_out("pend_rel", 6'b0, 1, 32'h100);
    step();
    drive(0,0,0,0,0,32'h0);
    chk_out("pend_after", 6'b0, 0, 32'h0);
    step();

    // watchdog: 8 consecutive stalled cycles
    rst = 1'b1; step(); rst = 1'b0;
    drive(0,0,1,0,0,32'h0);
    for (int i = 0; i < 7; i++) step();
    chk("wd.before", {31'd0, timeout_o}, 32'd0);
    step();
    chk("wd.set", {31'd0, timeout_o}, 32'd1);
    drive(0,0,0,0,0,32'h0);
    step(); step();
    chk("wd.sticky", {31'd0, timeout_o}, 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("wd.rst", {31'd0, timeout_o}, 32'd0);

    // reset while pending discards the redirect
    drive(0,0,1,0,1,32'h200);
    chk_out("rp.enter", 6'b001111, 0, 32'h0);
    step();
    rst = 1'b1;
    drive(0,0,1,0,1,32'h200);
    chk_out("rp.rst", 6'b0, 0, 32'h0);
    step();
    rst = 1'b0;
    drive(0,0,1,0,0,32'h0);
    chk_out("rp.held", 6'b001111, 0, 32'h0);
    step();
    drive(0,0,0,0,0,32'h0);
    chk_out("rp.release", 6'b0, 0, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
    chk("rp.perf_flush", perf_flush_cnt_o, 32'd0);
    chk("rp.perf_stall", perf_stall_cyc_o, 32'd1);
`endif
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
